fmap_unpad_stream: RTL and testbench
====================================

Name: fmap_unpad_stream

Overview:
- Streaming inverse of the zero-padding stage inside the CSP/CBS chain: consumes a zero-padded feature map one 16-bit element per beat, drops the P-wide border and emits only interior elements, in order, on a valid/ready stream.
- Sits after a padded-map producer; feeds CBS inputs or the result-readback path.
- Checks that border elements really are zero and that input framing matches the parameterised geometry.

Parameters:
- DATA_WIDTH, 16, element width (half-float bit pattern, passed through untouched).
- K, 2, number of channels per frame.
- HP, 4, padded height.
- WP, 4, padded width.
- P, 1, pad width on each side; requires HP>2P and WP>2P.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  DATA_WIDTH  padded-map element; order is channel-major, then row, then column.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks the final element of a padded frame (K*HP*WP-th beat).
- in_ready  out  1  element accepted when in_valid&&in_ready.
- out_data  out  DATA_WIDTH  interior element.
- out_valid  out  1  out_data valid.
- out_last  out  1  asserted with the final interior element of the frame.
- out_ready  in  1  consumer accepts when out_valid&&out_ready.
- frame_done  out  1  one-cycle pulse the cycle after the expected final input element is accepted.
- pad_err  out  1  sticky: a nonzero border element was seen in the current or last frame.
- frame_err  out  1  sticky: in_last position mismatch.

Behaviour:
- Reset (async, any time, including mid-frame): out_valid=0, out_data=0, out_last=0, frame_done=0, pad_err=0, frame_err=0. Counters col=row=ch=0. State=IDLE. The partial frame is discarded.
- States:
  - IDLE: no element of the current frame accepted yet.
  - RUN: inside a frame.
  - Transitions: IDLE->RUN on the first accept. RUN->IDLE on the accept of the expected final element (ch=K-1, row=HP-1, col=WP-1), or on an early in_last.
- Output register is single-entry: in_ready = !out_valid || out_ready. This is combinational from out_ready; there is no other input-to-output combinational path.
- On accept:
  - interior = (row>=P && row<HP-P && col>=P && col<WP-P).
  - Interior element: out_data<=in_data, out_valid<=1. out_last<=1 iff ch=K-1, row=HP-P-1, col=WP-P-1.
  - Border element: dropped. If in_data!=0, set pad_err. out_valid<=0 if the held element was consumed this cycle, otherwise it holds.
  - Latency: one cycle from interior accept to out_valid.
- No accept but out_valid&&out_ready: out_valid<=0, out_last<=0.
- Counters:
  - col increments; wraps at WP-1 to 0 and increments row.
  - row wraps at HP-1 to 0 and increments ch.
  - ch wraps at K-1 to 0, which is the end of the frame.
- Framing checks:
  - in_last on an accept at the expected final position is normal.
  - in_last on an accept elsewhere: set frame_err, reset counters to 0, go to IDLE, no frame_done.
  - Expected final element accepted without in_last: set frame_err. Counters still wrap and frame_done still pulses.
- frame_done pulses for one cycle on the cycle after the expected final accept.
- Sticky flags: pad_err and frame_err clear on the first accept of the next frame (IDLE->RUN). The first-beat error check is applied after that clear, so an error on the first beat is kept.
- Output stalls: with out_ready held low and out_valid=1, in_ready=0. No input is lost and out_data is stable.
- Back-to-back frames: the first element of frame N+1 may be accepted in the same cycle frame_done for frame N is high. Full throughput is 1 element/cycle when out_ready=1.
- Per frame, output count is exactly K*(HP-2P)*(WP-2P).

Test Plan:
- Default parameters, out_ready=1, one padded frame of 32 beats with interior values 1..8 (ch0 rows 1-2 cols 1-2 = 1,2,3,4; ch1 = 5,6,7,8) and zero border, in_last on beat 32:
  - out sequence 1..8, with out_last only on 8.
  - frame_done pulses once; pad_err=0, frame_err=0.
- Same frame with the border element at ch0 row0 col3 = 16'h3C00:
  - pad_err=1 after that beat; outputs are still 1..8.
  - Next frame with clean data: pad_err clears on its first beat.
- out_ready toggles 1,0,0,1 repeatedly through the frame:
  - in_ready low whenever out_valid=1 and out_ready=0.
  - Exactly 8 outputs in order, with no duplicates.
- in_last asserted on beat 20:
  - frame_err=1, no frame_done.
  - The following clean 32-beat frame produces 1..8 correctly and clears frame_err.
- reset pulsed (async, mid-cycle) after beat 10 of a frame:
  - All outputs go to 0 immediately.
  - The next full frame outputs 1..8 with correct out_last.
- Two frames back-to-back with in_valid=1 continuously and out_ready=1:
  - 16 outputs with no bubbles from the unpadder beyond border drops.
  - frame_done pulses after beat 32 and after beat 64.

Source files
------------

// File: rtl/fmap_unpad_stream.sv
// fmap_unpad_stream: strips the P-wide zero border from a padded feature-map stream
module fmap_unpad_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int K          = 2,
    parameter int HP         = 4,
    parameter int WP         = 4,
    parameter int P          = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic                  pad_err,
    output logic                  frame_err
);
    localparam int CW = (WP > 1) ? $clog2(WP) : 1;
    localparam int RW = (HP > 1) ? $clog2(HP) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [KW-1:0]         ch_q, ch_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  frame_done_q, frame_done_d;
    logic                  pad_err_q, pad_err_d;
    logic                  frame_err_q, frame_err_d;
    logic                  accept, interior, col_wrap, row_wrap, ch_wrap, at_final, at_last_int;

    assign in_ready    = !out_valid_q || out_ready;
    assign accept      = in_valid && in_ready;
    assign col_wrap    = col_q == CW'(WP - 1);
    assign row_wrap    = row_q == RW'(HP - 1);
    assign ch_wrap     = ch_q == KW'(K - 1);
    assign at_final    = col_wrap && row_wrap && ch_wrap;
    assign interior    = row_q >= RW'(P) && row_q < RW'(HP - P) && col_q >= CW'(P) && col_q < CW'(WP - P);
    assign at_last_int = ch_wrap && row_q == RW'(HP - P - 1) && col_q == CW'(WP - P - 1);

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign pad_err    = pad_err_q;
    assign frame_err  = frame_err_q;

    // Next-state: position counters, output slot, framing and border checks
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        ch_d         = ch_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        pad_err_d    = pad_err_q;
        frame_err_d  = frame_err_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (accept) begin
            if (state_q == IDLE) begin
                pad_err_d   = 1'b0;
                frame_err_d = 1'b0;
            end
            if (interior) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
                out_last_d  = at_last_int;
            end else if (in_data != '0) begin
                pad_err_d = 1'b1;
            end
            if (in_last && !at_final) begin
                frame_err_d = 1'b1;
                col_d       = '0;
                row_d       = '0;
                ch_d        = '0;
                state_d     = IDLE;
            end else begin
                state_d      = at_final ? IDLE : RUN;
                frame_done_d = at_final;
                frame_err_d  = (at_final && !in_last) ? 1'b1 : frame_err_d;
                col_d        = col_wrap ? '0 : col_q + 1'b1;
                row_d        = col_wrap ? (row_wrap ? '0 : row_q + 1'b1) : row_q;
                ch_d         = (col_wrap && row_wrap) ? (ch_wrap ? '0 : ch_q + 1'b1) : ch_q;
            end
        end
    end

    // State register with asynchronous reset discarding any partial frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            ch_q         <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            pad_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            ch_q         <= ch_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            pad_err_q    <= pad_err_d;
            frame_err_q  <= frame_err_d;
        end
    end
endmodule

// File: tb/tb_fmap_unpad_stream.sv
// tb_fmap_unpad_stream: randomized bench against a position-based reference model
module tb_fmap_unpad_stream;
    localparam int DW = 16;
    localparam int K  = 2;
    localparam int HP = 4;
    localparam int WP = 4;
    localparam int P  = 1;
    localparam int N  = K * HP * WP;
    localparam int NI = K * (HP - 2 * P) * (WP - 2 * P);

    logic          clk = 1'b0;
    logic          reset, in_valid, in_last, in_ready, out_valid, out_last, out_ready;
    logic          frame_done, pad_err, frame_err;
    logic [DW-1:0] in_data, out_data;

    always #5 clk = ~clk;

    fmap_unpad_stream #(.DATA_WIDTH(DW), .K(K), .HP(HP), .WP(WP), .P(P)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .frame_done(frame_done), .pad_err(pad_err), .frame_err(frame_err)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int rmode   = 0;
    int dut_outs, pos, cy;
    bit ref_ov, ref_last, ref_pad, ref_ferr, ref_done, acc;
    logic [DW-1:0] ref_data;
    logic [DW-1:0] fbuf [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pick();
        if (rmode == 0) return 1'b1;
        if (rmode == 1) return (cyc % 4 == 0) || (cyc % 4 == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_interior(input int p);
        int r, c;
        r = (p / WP) % HP;
        c = p % WP;
        return r >= P && r < HP - P && c >= P && c < WP - P;
    endfunction

    task automatic model_reset();
        pos = 0; ref_ov = 0; ref_last = 0; ref_pad = 0; ref_ferr = 0; ref_done = 0; ref_data = '0;
    endtask

    // called at a falling edge with inputs set; checks, advances the model, returns at next falling edge
    task automatic step();
        bit rdy, done_n;
        int c, r, col;
        #1;
        rdy = !ref_ov || out_ready;
        check("in_ready", in_ready, rdy);
        check("out_valid", out_valid, ref_ov);
        if (ref_ov) begin
            check("out_data", out_data, ref_data);
            check("out_last", out_last, ref_last);
        end
        check("pad_err", pad_err, ref_pad);
        check("frame_err", frame_err, ref_ferr);
        check("frame_done", frame_done, ref_done);
        if (out_valid && out_ready) dut_outs++;
        done_n = 0;
        acc = in_valid && rdy;
        if (ref_ov && out_ready) ref_ov = 0;
        if (acc) begin
            if (pos == 0) begin
                ref_pad = 0;
                ref_ferr = 0;
            end
            c = pos / (HP * WP);
            r = (pos / WP) % HP;
            col = pos % WP;
            if (is_interior(pos)) begin
                ref_ov = 1;
                ref_data = in_data;
                ref_last = (c == K - 1 && r == HP - P - 1 && col == WP - P - 1);
            end else if (in_data != 0) begin
                ref_pad = 1;
            end
            if (pos == N - 1) begin
                if (!in_last) ref_ferr = 1;
                done_n = 1;
                pos = 0;
            end else if (in_last) begin
                ref_ferr = 1;
                pos = 0;
            end else begin
                pos++;
            end
        end
        @(negedge clk);
        cyc++;
        ref_done = done_n;
        out_ready = pick();
    endtask

    task automatic build(input bit seq);
        int v;
        v = 1;
        for (int i = 0; i < N; i++) begin
            if (is_interior(i)) begin
                fbuf[i] = seq ? DW'(v) : DW'($urandom_range(1, 65535));
                v++;
            end else begin
                fbuf[i] = '0;
            end
        end
    endtask

    task automatic send_frame(input int last_at, input int nbeats, input bit gaps, output int cycles);
        int guard;
        cycles = 0;
        for (int b = 0; b < nbeats; b++) begin
            guard = 0;
            acc = 0;
            while (!acc) begin
                in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data = fbuf[b];
                in_last = (b == last_at);
                step();
                cycles++;
                guard++;
                if (!acc && guard > 200) begin
                    check("accept_timeout", 0, 1);
                    in_valid = 0;
                    in_last = 0;
                    return;
                end
            end
        end
        in_valid = 0;
        in_last = 0;
        in_data = '0;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        in_last = 0;
        repeat (n) step();
    endtask

    initial begin
        reset = 1; in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;
        model_reset();
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_pad_err", pad_err, 0);
        check("rst_frame_err", frame_err, 0);
        @(negedge clk);
        reset = 0;

        rmode = 0; build(1); dut_outs = 0;
        send_frame(N - 1, N, 0, cy); idle(4);
        check("clean_outs", dut_outs, NI);

        build(1); fbuf[WP - 1] = 16'h3C00; dut_outs = 0;
        send_frame(N - 1, N, 0, cy); idle(4);
        check("pad_outs", dut_outs, NI);
        check("pad_err_set", pad_err, 1);
        build(1); dut_outs = 0;
        send_frame(N - 1, N, 0, cy); idle(4);
        check("pad_err_cleared", pad_err, 0);

        rmode = 1; build(1); dut_outs = 0;
        send_frame(N - 1, N, 0, cy); idle(8);
        check("stall_outs", dut_outs, NI);

        rmode = 0; build(1); dut_outs = 0;
        send_frame(19, 20, 0, cy); idle(4);
        check("early_last_err", frame_err, 1);
        check("early_last_outs", dut_outs, 4);
        build(1); dut_outs = 0;
        send_frame(N - 1, N, 0, cy); idle(4);
        check("after_early_outs", dut_outs, NI);
        check("frame_err_cleared", frame_err, 0);

        build(1);
        send_frame(-1, 10, 0, cy);
        #2 reset = 1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_last", out_last, 0);
        check("arst_pad_err", pad_err, 0);
        check("arst_frame_err", frame_err, 0);
        #1 reset = 0;
        model_reset();
        @(negedge clk);
        dut_outs = 0;
        send_frame(N - 1, N, 0, cy); idle(4);
        check("post_rst_outs", dut_outs, NI);

        build(1); dut_outs = 0;
        send_frame(N - 1, N, 0, cy);
        check("b2b_cycles_1", cy, N);
        build(0);
        send_frame(N - 1, N, 0, cy);
        check("b2b_cycles_2", cy, N);
        idle(4);
        check("b2b_outs", dut_outs, 2 * NI);

        rmode = 2;
        for (int f = 0; f < 8; f++) begin
            build(0);
            if ($urandom_range(0, 2) == 0) fbuf[0] = DW'($urandom_range(1, 65535));
            if ($urandom_range(0, 2) == 0) fbuf[N - 1] = DW'($urandom_range(1, 65535));
            dut_outs = 0;
            send_frame(($urandom_range(0, 3) == 0) ? -1 : N - 1, N, 1, cy);
            idle(12);
            check("rand_outs", dut_outs, NI);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
